// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: 8-LED pattern sequencer with internal step tick and button debouncer.
// Optional feature macro: LED_SEQ_PINGPONG_EN (mode 10 = PINGPONG; otherwise mode 10 = ROTATE).
module led_seq_ctrl #(
  parameter int unsigned CLK_HZ     = 125000000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned DEB_CYCLES = 1250000,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic [1:0]       mode_sw,
  input  logic             run_sw,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic [1:0]       state,
  output logic             btn_db
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = $clog2(DIV);
  localparam int unsigned DW  = $clog2(DEB_CYCLES + 1);

  localparam logic [1:0] M_SHIFT    = 2'b00;
  localparam logic [1:0] M_ROTATE   = 2'b01;
  localparam logic [1:0] M_PINGPONG = 2'b10;
  localparam logic [1:0] M_FILL     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [WIDTH-1:0] r_led;
  logic [WIDTH-1:0] w_led_nx;
  logic [WIDTH-1:0] w_step_led;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic             r_tick;
  logic             w_tick_nx;
  logic [1:0]       r_mode_q;
  logic [1:0]       w_mode_q_nx;
`ifdef LED_SEQ_PINGPONG_EN
  logic             r_dir;       // 1 = moving toward led[WIDTH-1]
  logic             w_dir_nx;
  logic             w_step_dir;
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic             r_btn_db;
  logic             r_btn_db_d;
  logic [DW-1:0]    r_deb_cnt;
  logic             w_btn_rise;

  // Two-flop synchronizer plus stable-count debouncer; any bounce clears the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_deb_cnt  <= '0;
    end else begin
      r_sync1    <= btn_in;
      r_sync2    <= r_sync1;
      r_btn_db_d <= r_btn_db;
      if (r_sync2 != r_btn_db) begin
        if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
          r_btn_db  <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DW'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  assign w_btn_rise = r_btn_db & ~r_btn_db_d;

  // Pattern advance for one step of the active mode
  always_comb begin
    w_step_led = r_led;
`ifdef LED_SEQ_PINGPONG_EN
    w_step_dir = r_dir;
`endif
    case (r_mode_q)
      M_SHIFT:  w_step_led = {r_led[WIDTH-2:0], r_btn_db};
      M_ROTATE: w_step_led = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
`ifdef LED_SEQ_PINGPONG_EN
      M_PINGPONG: begin
        // Reverse on reaching an end so each end is lit for a single step
        if (r_dir) begin
          if (r_led[WIDTH-1]) begin
            w_step_led = r_led >> 1;
            w_step_dir = 1'b0;
          end else begin
            w_step_led = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_step_led = r_led << 1;
            w_step_dir = 1'b1;
          end else begin
            w_step_led = r_led >> 1;
          end
        end
      end
`else
      M_PINGPONG: w_step_led = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
`endif
      M_FILL: begin
        if (&r_led) w_step_led = '0;
        else        w_step_led = {r_led[WIDTH-2:0], 1'b1};
      end
      default: w_step_led = r_led;
    endcase
  end

  // Next-state, counter, LED and registered-output decode
  always_comb begin
    w_state_nx  = r_state;
    w_led_nx    = r_led;
    w_cnt_nx    = r_cnt;
    w_mode_q_nx = r_mode_q;
`ifdef LED_SEQ_PINGPONG_EN
    w_dir_nx    = r_dir;
`endif
    case (r_state)
      ST_IDLE: begin
        w_led_nx = '0;
        w_cnt_nx = '0;
        if (run_sw) w_state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        w_cnt_nx   = '0;
        w_state_nx = ST_RUN;
        case (r_mode_q)
          M_SHIFT:  w_led_nx = r_led;
          M_ROTATE: if (r_led == '0) w_led_nx = WIDTH'(1);
`ifdef LED_SEQ_PINGPONG_EN
          M_PINGPONG: begin
            w_led_nx = WIDTH'(1);
            w_dir_nx = 1'b1;
          end
`else
          M_PINGPONG: if (r_led == '0) w_led_nx = WIDTH'(1);
`endif
          M_FILL:   w_led_nx = '0;
          default:  w_led_nx = r_led;
        endcase
      end
      ST_RUN: begin
        w_cnt_nx = (r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + CW'(1);
        if (!run_sw) begin
          w_state_nx = ST_PAUSE;
        end else if (mode_sw != r_mode_q) begin
          w_state_nx = ST_LOAD;
        end else if (w_btn_rise && (r_mode_q != M_SHIFT)) begin
          w_state_nx = ST_LOAD;
        end else if (r_tick) begin
          w_led_nx = w_step_led;
`ifdef LED_SEQ_PINGPONG_EN
          w_dir_nx = w_step_dir;
`endif
        end
      end
      ST_PAUSE: begin
        if (run_sw) w_state_nx = (mode_sw != r_mode_q) ? ST_LOAD : ST_RUN;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // Mode is captured on entry to LOAD so the LOAD action already sees it
    if (w_state_nx == ST_LOAD) w_mode_q_nx = mode_sw;
    w_tick_nx = (w_state_nx == ST_RUN) && (w_cnt_nx == CW'(DIV - 1));
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_led    <= '0;
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_mode_q <= M_SHIFT;
`ifdef LED_SEQ_PINGPONG_EN
      r_dir    <= 1'b1;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_led    <= w_led_nx;
      r_cnt    <= w_cnt_nx;
      r_tick   <= w_tick_nx;
      r_mode_q <= w_mode_q_nx;
`ifdef LED_SEQ_PINGPONG_EN
      r_dir    <= w_dir_nx;
`endif
    end
  end

  assign led    = r_led;
  assign tick   = r_tick;
  assign state  = r_state;
  assign btn_db = r_btn_db;

endmodule
